mips_pipe_reg: RTL and testbench
================================

# mips_pipe_reg

Parametrised elastic pipeline register, the next generation of the fixed MEM/WB register in the MIPS pipeline. It carries an opaque payload (control bits, destination register, ALU result, load data) through STAGES register slots using a valid/ready handshake. It also supports synchronous flush and stall back-pressure. It replaces hard-wired per-stage registers between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and produces zero-payload bubbles, so a bubble always has reg_wr=0.

## Interface
- PAYLOAD_W, 71, payload width in bits (MEM/WB default: 1 reg_wr + 1 mem_to_reg + 5 rd + 32 ALU result + 32 read data).
- STAGES, 1, number of register slots in series; legal range 1..8.
- CNT_W, $clog2(2*STAGES+1), occupancy counter width (derived; not overridden).

- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush_i  input  1  synchronous flush; kills all held entries and the input beat.
- in_valid_i  input  1  upstream beat present.
- in_ready_o  output  1  block accepts a beat this cycle.
- in_data_i  input  PAYLOAD_W  upstream payload.
- out_valid_o  output  1  downstream beat present.
- out_ready_i  input  1  downstream accepts a beat this cycle.
- out_data_o  output  PAYLOAD_W  downstream payload; all-zero whenever out_valid_o=0.
- occupancy_o  output  CNT_W  number of valid entries currently held.

## Operation
- Transfer in: in_valid_i && in_ready_o. Transfer out: out_valid_o && out_ready_i.
- Each slot holds valid bit plus payload. Slot s loads from slot s-1 (or input for s=0) when slot s is empty or slot s's content moves on this cycle.
- Without the skid option: ready_s = !valid_s || ready_{s+1}; ready after last slot = out_ready_i. in_ready_o = ready_0. This is a combinational ready chain.
- Slot invalidated without reload: payload forced to zero (bubble). A slot never holds a non-zero payload with valid=0.
- Stall: out_ready_i=0 with all slots full → in_ready_o=0, contents frozen bit-exact.
- Flush: all valid bits and payloads cleared next edge; in_ready_o forced 1 during flush_i; any input beat in that cycle is discarded; out transfer in that cycle still counts downstream (downstream owns squash decision).
- occupancy_o: +1 on accepted, non-flushed input; −1 on output transfer; both → unchanged; flush → 0. Never exceeds capacity (STAGES, or 2*STAGES with skid).
- Payload bits are not interpreted; no arithmetic on payload.

## Timing
- Reset: out_valid_o=0, out_data_o=0, occupancy_o=0, all slots zero. in_ready_o=1 (combinational, reset released).
- Latency: beat accepted at edge N appears on out_valid_o/out_data_o after edge N+STAGES when no stall.
- Throughput: one beat per cycle sustained when out_ready_i=1.
- Reset asserted mid-stream: all held beats lost immediately (asynchronous), no output beat produced after.
- Simultaneous flush_i and reset: reset dominates (same result).
- out_valid_o and out_data_o are register outputs, with no combinational path from inputs.

## Configuration
- PIPE_REG_SKID_EN defined: each slot gains one skid register; ready to upstream of each slot = !skid_valid (registered). There is no combinational path from out_ready_i to in_ready_o. Capacity 2*STAGES; latency unchanged when unstalled; skid drains first (order preserved). Flush also clears skid entries.
- Undefined: no skid registers; combinational ready chain as above; capacity STAGES.

## Test plan
- Reset then STAGES=1, stream payloads 1,2,3 with out_ready_i=1 → out_data_o 1,2,3 on consecutive cycles, one cycle after each accept; occupancy_o stays 1.
- STAGES=3, 0x2A accepted at edge 0 → out_valid_o=1, out_data_o=0x2A after edge 3; earlier cycles out_valid_o=0, out_data_o=0.
- STAGES=2, hold out_ready_i=0 and feed 5 beats → only 2 accepted (4 with PIPE_REG_SKID_EN), in_ready_o=0 afterwards, occupancy_o=2 (4). Release → beats exit in order with no loss or duplicate.
- Full pipe, flush_i pulsed with in_valid_i=1 → next cycle out_valid_o=0, out_data_o=0, occupancy_o=0; flushed input never emerges.
- Assert reset asynchronously mid-cycle with 2 beats held → outputs go to 0 before next clock edge; after release, in_ready_o=1.
- PIPE_REG_SKID_EN build: toggle out_ready_i every cycle → in_ready_o changes only on clock edges; all beats delivered in order.

Source files
------------

// File: rtl/mips_pipe_reg.sv
// mips_pipe_reg: elastic valid/ready pipeline register, STAGES slots deep; empty slots always hold zero payload.
// Optional build macro PIPE_REG_SKID_EN adds one skid register per slot and makes in_ready_o fully registered.
module mips_pipe_reg #(
   parameter int PAYLOAD_W = 71,
   parameter int STAGES    = 1,
   parameter int CNT_W     = $clog2(2*STAGES+1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [PAYLOAD_W-1:0] in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PAYLOAD_W-1:0] out_data_o,
   output logic [CNT_W-1:0]     occupancy_o
);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [STAGES-1:0]    valid_r;
   logic [PAYLOAD_W-1:0] data_r [STAGES];
   logic [STAGES:0]      ready_s;    // ready_s[s]: slot s can take a beat; [STAGES] is out_ready_i
   logic [STAGES-1:0]    up_valid_s;
   logic [PAYLOAD_W-1:0] up_data_s [STAGES];
   logic                 in_fire_s;
   logic                 out_fire_s;
   logic [CNT_W-1:0]     cnt_r;
`ifdef PIPE_REG_SKID_EN
   logic [STAGES-1:0]    skid_valid_r;
   logic [PAYLOAD_W-1:0] skid_data_r [STAGES];
`endif

   // Beat offered to each slot: the block input for slot 0, the previous slot otherwise.
   always_comb begin
      up_valid_s[0] = in_valid_i;
      up_data_s[0]  = in_data_i;
      for (int s = 1; s < STAGES; s++) begin
         up_valid_s[s] = valid_r[s-1];
         up_data_s[s]  = data_r[s-1];
      end
   end

`ifdef PIPE_REG_SKID_EN
   // Each slot accepts while its skid register is free, so ready never depends on out_ready_i.
   always_comb begin
      ready_s[STAGES] = out_ready_i;
      for (int s = 0; s < STAGES; s++) begin
         ready_s[s] = ~skid_valid_r[s];
      end
   end
`else
   // Combinational ready chain, unrolled: a slot is ready when it or any later slot is empty, or out_ready_i.
   always_comb begin : ready_chain
      logic acc_s;
      acc_s           = out_ready_i;
      ready_s[STAGES] = out_ready_i;
      for (int s = STAGES - 1; s >= 0; s--) begin
         acc_s      = acc_s | ~valid_r[s];
         ready_s[s] = acc_s;
      end
   end
`endif

   assign in_ready_o  = flush_i | ready_s[0];
   assign in_fire_s   = in_valid_i & ready_s[0] & ~flush_i;
   assign out_fire_s  = valid_r[STAGES-1] & out_ready_i;
   assign out_valid_o = valid_r[STAGES-1];
   assign out_data_o  = data_r[STAGES-1];
   assign occupancy_o = cnt_r;

   // Slot storage: load when empty or draining; an invalid load writes a zero bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_r[s] <= '0;
         end
`ifdef PIPE_REG_SKID_EN
         skid_valid_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            skid_data_r[s] <= '0;
         end
`endif
      end else if (flush_i) begin
         valid_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_r[s] <= '0;
         end
`ifdef PIPE_REG_SKID_EN
         skid_valid_r <= '0;
         for (int s = 0; s < STAGES; s++) begin
            skid_data_r[s] <= '0;
         end
`endif
      end else begin
         for (int s = 0; s < STAGES; s++) begin
`ifdef PIPE_REG_SKID_EN
            if (!valid_r[s] || ready_s[s+1]) begin
               // Skid content is older than anything upstream, so it goes first.
               if (skid_valid_r[s]) begin
                  valid_r[s]      <= 1'b1;
                  data_r[s]       <= skid_data_r[s];
                  skid_valid_r[s] <= 1'b0;
                  skid_data_r[s]  <= '0;
               end else begin
                  valid_r[s] <= up_valid_s[s];
                  data_r[s]  <= up_valid_s[s] ? up_data_s[s] : '0;
               end
            end else if (up_valid_s[s] && ready_s[s]) begin
               skid_valid_r[s] <= 1'b1;
               skid_data_r[s]  <= up_data_s[s];
            end
`else
            if (ready_s[s]) begin
               valid_r[s] <= up_valid_s[s];
               data_r[s]  <= up_valid_s[s] ? up_data_s[s] : '0;
            end
`endif
         end
      end
   end

   // Occupancy tracks accepted minus delivered beats; a flush empties everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (flush_i) begin
         cnt_r <= '0;
      end else begin
         case ({in_fire_s, out_fire_s})
            2'b10:   cnt_r <= cnt_r + CNT_ONE;
            2'b01:   cnt_r <= cnt_r - CNT_ONE;
            default: cnt_r <= cnt_r;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_pipe_reg.sv
// Directed self-checking bench for mips_pipe_reg: three instances (STAGES=1, 3, 2).
// Expectations adapt to the PIPE_REG_SKID_EN build macro where capacity or ready timing differ.
module tb_mips_pipe_reg;
`ifdef PIPE_REG_SKID_EN
   localparam int CAP_C = 4;
`else
   localparam int CAP_C = 2;
`endif

   logic clk = 1'b0;
   logic reset;
   logic flush;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [70:0] in_data_a, out_data_a;
   logic [1:0]  occ_a;

   logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [7:0] in_data_b, out_data_b;
   logic [2:0] occ_b;

   logic       in_valid_c, in_ready_c, out_valid_c, out_ready_c;
   logic [7:0] in_data_c, out_data_c;
   logic [2:0] occ_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mips_pipe_reg #(.PAYLOAD_W(71), .STAGES(1)) dut_a (
      .clk(clk), .reset(reset), .flush_i(1'b0),
      .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_data_i(in_data_a),
      .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .out_data_o(out_data_a),
      .occupancy_o(occ_a));

   mips_pipe_reg #(.PAYLOAD_W(8), .STAGES(3)) dut_b (
      .clk(clk), .reset(reset), .flush_i(1'b0),
      .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data_b),
      .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b),
      .occupancy_o(occ_b));

   mips_pipe_reg #(.PAYLOAD_W(8), .STAGES(2)) dut_c (
      .clk(clk), .reset(reset), .flush_i(flush),
      .in_valid_i(in_valid_c), .in_ready_o(in_ready_c), .in_data_i(in_data_c),
      .out_valid_o(out_valid_c), .out_ready_i(out_ready_c), .out_data_o(out_data_c),
      .occupancy_o(occ_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0;
      in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
      in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
      in_valid_c = 1'b0; in_data_c = '0; out_ready_c = 1'b0;
      @(posedge clk);
      #2;
      n_checks++;
      if ({out_valid_a, out_data_a, occ_a} !== 74'd0) begin
         n_fail++; $display("FAIL reset_a: got v=%b d=%h occ=%0d, want all zero", out_valid_a, out_data_a, occ_a);
      end
      n_checks++;
      if ({out_valid_b, out_data_b, occ_b} !== 12'd0) begin
         n_fail++; $display("FAIL reset_b: got v=%b d=%h occ=%0d, want all zero", out_valid_b, out_data_b, occ_b);
      end
      n_checks++;
      if ({out_valid_c, out_data_c, occ_c} !== 12'd0) begin
         n_fail++; $display("FAIL reset_c: got v=%b d=%h occ=%0d, want all zero", out_valid_c, out_data_c, occ_c);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b111) begin
         n_fail++; $display("FAIL reset_ready: got %b%b%b, want 111", in_ready_a, in_ready_b, in_ready_c);
      end
   endtask

   task automatic test_stream();
      out_ready_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_valid_a = 1'b1;
         in_data_a  = 71'(i);
         step();
         n_checks++;
         if (out_valid_a !== 1'b1 || out_data_a !== 71'(i) || occ_a !== 2'd1) begin
            n_fail++; $display("FAIL stream_%0d: got v=%b d=%0h occ=%0d, want v=1 d=%0h occ=1", i, out_valid_a, out_data_a, occ_a, i);
         end
      end
      in_valid_a = 1'b0;
      in_data_a  = '0;
      step();
      n_checks++;
      if (out_valid_a !== 1'b0 || out_data_a !== 71'd0 || occ_a !== 2'd0) begin
         n_fail++; $display("FAIL stream_drain: got v=%b d=%0h occ=%0d, want 0 0 0", out_valid_a, out_data_a, occ_a);
      end
   endtask

   task automatic test_latency();
      out_ready_b = 1'b1;
      step();
      in_valid_b = 1'b1;
      in_data_b  = 8'h2A;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (out_valid_b !== 1'b0 || out_data_b !== 8'h00) begin
            n_fail++; $display("FAIL latency_early_%0d: got v=%b d=%h, want v=0 d=00", k, out_valid_b, out_data_b);
         end
         step();
         in_valid_b = 1'b0;
         in_data_b  = 8'h00;
      end
      n_checks++;
      if (out_valid_b !== 1'b1 || out_data_b !== 8'h2A || occ_b !== 3'd1) begin
         n_fail++; $display("FAIL latency_out: got v=%b d=%h occ=%0d, want v=1 d=2a occ=1", out_valid_b, out_data_b, occ_b);
      end
      step();
      n_checks++;
      if (out_valid_b !== 1'b0 || out_data_b !== 8'h00 || occ_b !== 3'd0) begin
         n_fail++; $display("FAIL latency_after: got v=%b d=%h occ=%0d, want 0 00 0", out_valid_b, out_data_b, occ_b);
      end
   endtask

   task automatic test_stall();
      out_ready_c = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid_c = 1'b1;
         in_data_c  = 8'(8'h11 + i);
         #1;
         n_checks++;
         if (in_ready_c !== (i < CAP_C)) begin
            n_fail++; $display("FAIL stall_ready_%0d: got %b, want %b", i, in_ready_c, (i < CAP_C));
         end
         step();
      end
      n_checks++;
      if (occ_c !== 3'(CAP_C) || in_ready_c !== 1'b0 || out_valid_c !== 1'b1 || out_data_c !== 8'h11) begin
         n_fail++; $display("FAIL stall_full: got occ=%0d rdy=%b v=%b d=%h, want occ=%0d rdy=0 v=1 d=11", occ_c, in_ready_c, out_valid_c, out_data_c, CAP_C);
      end
      in_valid_c  = 1'b0;
      out_ready_c = 1'b1;
      for (int j = 0; j < CAP_C; j++) begin
         n_checks++;
         if (out_valid_c !== 1'b1 || out_data_c !== 8'(8'h11 + j)) begin
            n_fail++; $display("FAIL stall_drain_%0d: got v=%b d=%h, want v=1 d=%h", j, out_valid_c, out_data_c, 8'(8'h11 + j));
         end
         step();
      end
      n_checks++;
      if (out_valid_c !== 1'b0 || out_data_c !== 8'h00 || occ_c !== 3'd0) begin
         n_fail++; $display("FAIL stall_empty: got v=%b d=%h occ=%0d, want 0 00 0", out_valid_c, out_data_c, occ_c);
      end
   endtask

   task automatic test_flush();
      out_ready_c = 1'b0;
      for (int i = 0; i < CAP_C; i++) begin
         in_valid_c = 1'b1;
         in_data_c  = 8'(8'h51 + i);
         step();
      end
      in_data_c = 8'h77;
      flush     = 1'b1;
      #1;
      n_checks++;
      if (in_ready_c !== 1'b1) begin
         n_fail++; $display("FAIL flush_ready: got %b, want 1", in_ready_c);
      end
      step();
      flush      = 1'b0;
      in_valid_c = 1'b0;
      n_checks++;
      if (out_valid_c !== 1'b0 || out_data_c !== 8'h00 || occ_c !== 3'd0) begin
         n_fail++; $display("FAIL flush_clear: got v=%b d=%h occ=%0d, want 0 00 0", out_valid_c, out_data_c, occ_c);
      end
      out_ready_c = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (out_valid_c !== 1'b0 || out_data_c !== 8'h00) begin
            n_fail++; $display("FAIL flush_no_emerge_%0d: got v=%b d=%h, want v=0 d=00", k, out_valid_c, out_data_c);
         end
      end
   endtask

   task automatic test_async_reset();
      out_ready_c = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid_c = 1'b1;
         in_data_c  = 8'(8'h61 + i);
         step();
      end
      in_valid_c = 1'b0;
      n_checks++;
      if (occ_c !== 3'd2 || out_valid_c !== 1'b1) begin
         n_fail++; $display("FAIL areset_pre: got occ=%0d v=%b, want occ=2 v=1", occ_c, out_valid_c);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (out_valid_c !== 1'b0 || out_data_c !== 8'h00 || occ_c !== 3'd0) begin
         n_fail++; $display("FAIL areset_now: got v=%b d=%h occ=%0d, want 0 00 0", out_valid_c, out_data_c, occ_c);
      end
      #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (in_ready_c !== 1'b1) begin
         n_fail++; $display("FAIL areset_ready: got %b, want 1", in_ready_c);
      end
      out_ready_c = 1'b1;
      step();
      n_checks++;
      if (out_valid_c !== 1'b0) begin
         n_fail++; $display("FAIL areset_no_beat: got v=%b, want 0", out_valid_c);
      end
   endtask

   task automatic test_back_to_back();
      int  sent = 0;
      int  rcv  = 0;
      int  cyc  = 0;
      logic tog = 1'b0;
      logic rdy_before;
      while (rcv < 6 && cyc < 60) begin
         step();
         rdy_before  = in_ready_c;
         tog         = ~tog;
         out_ready_c = tog;
         in_valid_c  = (sent < 6);
         in_data_c   = 8'(8'h31 + sent);
         #1;
`ifdef PIPE_REG_SKID_EN
         n_checks++;
         if (in_ready_c !== rdy_before) begin
            n_fail++; $display("FAIL toggle_ready_comb_%0d: got %b, want %b", cyc, in_ready_c, rdy_before);
         end
`endif
         n_checks++;
         if (out_valid_c === 1'b0 && out_data_c !== 8'h00) begin
            n_fail++; $display("FAIL toggle_bubble_%0d: got d=%h with v=0, want 00", cyc, out_data_c);
         end
         if (out_valid_c && out_ready_c) begin
            n_checks++;
            if (out_data_c !== 8'(8'h31 + rcv)) begin
               n_fail++; $display("FAIL toggle_order_%0d: got %h, want %h", rcv, out_data_c, 8'(8'h31 + rcv));
            end
            rcv++;
         end
         if (in_valid_c && in_ready_c) sent++;
         cyc++;
      end
      in_valid_c = 1'b0;
      n_checks++;
      if (rcv != 6) begin
         n_fail++; $display("FAIL toggle_count: got %0d beats, want 6", rcv);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_latency();
      test_stall();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
